msg_sched: RTL
==============

Name: msg_sched

Overview:
- Shares the single byte coder between N message sources; the time-mark source is one of them.
- Each source presents bytes (q, q_rdy), advances on its own cd_busy, and pulses msg_end after its last byte.
- msg_sched grants one source at a time, muxes its bytes to the coder and routes cd_busy back only to that source.
- Inserts an inter-message gap and aborts a hung source via a watchdog.

Parameters:
- N_SRC, 3: number of message sources, 2..8; index 0 is highest priority in fixed mode.
- RR_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round robin.
- GAP_CYC, 4: idle clk cycles between messages, 1..255.
- TIMEOUT, 1023: max clk cycles a grant may last before abort, 16..65535.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- req  in  N_SRC  per-source message request (level).
- src_q  in  8*N_SRC  source byte buses; source i occupies bits [8i+7:8i].
- src_q_rdy  in  N_SRC  per-source byte-valid.
- src_msg_end  in  N_SRC  per-source end-of-message pulse (1 clk).
- src_cd_busy  out  N_SRC  coder busy, routed to the granted source only.
- gnt  out  N_SRC  one-hot grant; all-zero when no grant.
- cd_busy  in  1  busy from coder.
- cd_q  out  8  byte to coder.
- cd_q_rdy  out  1  byte-valid to coder.
- sched_busy  out  1  high in GRANT or GAP.
- timeout_err  out  1  1-clk pulse on watchdog abort.

Behaviour:
- Reset (async, any state, including mid-message): state=IDLE; gnt=0, src_cd_busy=0, cd_q=0, cd_q_rdy=0, sched_busy=0, timeout_err=0; rr pointer=0; gap and watchdog counters=0.
- States: IDLE, GRANT, GAP. All transitions on posedge clk.
- IDLE:
  - If req!=0, pick winner w and go to GRANT.
  - gnt=onehot(w) is registered, so it is visible 1 clk after req is sampled.
  - Fixed mode: w = lowest set index.
  - RR mode: w = first set index at or after rr_ptr, wrapping modulo N_SRC.
- GRANT:
  - cd_q = src_q[w]; cd_q_rdy = src_q_rdy[w]. Both combinational from the registered w.
  - src_cd_busy[w] = cd_busy; all other bits are 0.
  - Watchdog counts clk cycles from grant entry.
  - src_msg_end[w]=1 -> GAP. In RR mode rr_ptr <= (w+1) mod N_SRC. gnt drops on the next clk.
  - Watchdog reaches TIMEOUT with no msg_end -> timeout_err pulses 1 clk, go to GAP, rr_ptr advances as above.
  - If msg_end and watchdog expiry coincide, msg_end wins: no timeout_err.
  - Deassertion of req[w] mid-grant is ignored; the grant holds until msg_end or timeout.
  - src_msg_end from non-granted sources is ignored.
- GAP:
  - gnt=0, cd_q=0, cd_q_rdy=0, src_cd_busy=0.
  - Counts GAP_CYC clk cycles, then returns to IDLE.
  - Requests arriving during GAP are held by the sources (level) and arbitrated in IDLE.
  - Minimum spacing from msg_end to the next gnt = GAP_CYC+2 clk.
- Outside GRANT, cd_q and cd_q_rdy are forced to 0.
- sched_busy = (state != IDLE).
- Counter widths: watchdog 16 bit, gap 8 bit, rr_ptr clog2(N_SRC). No wrap: counters are cleared on every state entry.

Decomposition:
- Shared header msg_defs.vh gets:
  - state encodings SCHED_IDLE/SCHED_GRANT/SCHED_GAP;
  - source indices SRC_TM=0, SRC_TLM=1, SRC_STAT=2;
  - default GAP_CYC and TIMEOUT values.
- One combinational sub-module, msg_pick: inputs req, rr_ptr, RR_MODE; outputs winner index and a valid flag. The FSM, counters and muxing stay in msg_sched.

Test Plan:
- Single source: req=3'b001; source emits 4 bytes then msg_end -> gnt=001 1 clk after req; cd_q carries the 4 bytes; src_cd_busy[0] follows cd_busy and bits 1,2 stay 0; gnt drops; next grant no earlier than GAP_CYC+2=6 clk after msg_end.
- Fixed priority: RR_MODE=0, req=3'b110 held for 3 messages -> grants 010, 010, 010; source 2 is never granted.
- Round robin: RR_MODE=1, req=3'b111 held for 4 messages -> grant sequence 001, 010, 100, 001.
- Watchdog: TIMEOUT=16; granted source never pulses msg_end -> timeout_err high for exactly 1 clk, 16 clk after grant; gnt=0; after GAP, the next requester is served. Coincident msg_end on cycle 16 -> no timeout_err.
- Reset mid-message: assert rst asynchronously during the byte-2 transfer -> all outputs 0 immediately without a clk edge; after release with req=3'b100 in RR mode, grant=100 with rr_ptr restarted at 0.
- Isolation: msg_end pulsed by a non-granted source during GRANT and req[w] dropped mid-message -> grant unchanged until the granted source's own msg_end.

Source files
------------

// File: rtl/msg_sched_pkg.sv
// Shared definitions for the message scheduler: state encodings,
// well-known source indices and default timing parameters.
package msg_sched_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_GRANT = 2'd1,
    SCHED_GAP   = 2'd2
  } sched_state_e;

  localparam int SRC_TM   = 0;
  localparam int SRC_TLM  = 1;
  localparam int SRC_STAT = 2;

  localparam int DEF_GAP_CYC = 4;
  localparam int DEF_TIMEOUT = 1023;

endpackage

// File: rtl/msg_sched_pick.sv
// Combinational winner selection: lowest set index, or first set index
// at/after rr_ptr (wrapping) when RR_MODE is nonzero.
module msg_pick #(
  parameter int N_SRC   = 3,
  parameter int RR_MODE = 0,
  localparam int PW     = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [PW-1:0]    rr_ptr,
  output logic [PW-1:0]    win,
  output logic             win_vld
);

  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    win_vld = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = (RR_MODE != 0) ? (int'(rr_ptr) + k) % N_SRC : k;
      if (!win_vld && req[idx]) begin
        win     = PW'(idx);
        win_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/msg_sched.sv
// Grants the shared byte coder to one message source at a time, with an
// inter-message gap and a watchdog that aborts a hung source.
module msg_sched
  import msg_sched_pkg::*;
#(
  parameter int N_SRC   = 3,
  parameter int RR_MODE = 0,
  parameter int GAP_CYC = DEF_GAP_CYC,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   req,
  input  logic [8*N_SRC-1:0] src_q,
  input  logic [N_SRC-1:0]   src_q_rdy,
  input  logic [N_SRC-1:0]   src_msg_end,
  output logic [N_SRC-1:0]   src_cd_busy,
  output logic [N_SRC-1:0]   gnt,
  input  logic               cd_busy,
  output logic [7:0]         cd_q,
  output logic               cd_q_rdy,
  output logic               sched_busy,
  output logic               timeout_err
);

  localparam int PW = $clog2(N_SRC);

  sched_state_e  state, state_nxt;
  logic [PW-1:0] w_q, rr_ptr, pick_w, ptr_nxt;
  logic          pick_vld;
  logic [15:0]   wd_cnt;
  logic [7:0]    gap_cnt;
  logic          in_grant, own_end, wd_exp, gap_done;

  msg_pick #(.N_SRC(N_SRC), .RR_MODE(RR_MODE)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .win     (pick_w),
    .win_vld (pick_vld)
  );

  assign in_grant = (state == SCHED_GRANT);
  assign own_end  = src_msg_end[w_q];
  assign wd_exp   = (wd_cnt == 16'(TIMEOUT - 1));
  assign gap_done = (gap_cnt == 8'(GAP_CYC - 1));
  assign ptr_nxt  = (w_q == PW'(N_SRC - 1)) ? '0 : w_q + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      SCHED_IDLE:  if (pick_vld) state_nxt = SCHED_GRANT;
      SCHED_GRANT: if (own_end || wd_exp) state_nxt = SCHED_GAP;
      SCHED_GAP:   if (gap_done) state_nxt = SCHED_IDLE;
      default:     state_nxt = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SCHED_IDLE;
    else     state <= state_nxt;
  end

  // Counters are zeroed while in the state that precedes their use, so
  // every entry into GRANT or GAP starts counting from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q         <= '0;
      rr_ptr      <= '0;
      wd_cnt      <= '0;
      gap_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        SCHED_IDLE: begin
          wd_cnt  <= '0;
          gap_cnt <= '0;
          if (pick_vld) w_q <= pick_w;
        end
        SCHED_GRANT: begin
          wd_cnt  <= wd_cnt + 16'd1;
          gap_cnt <= '0;
          if (own_end || wd_exp) begin
            if (RR_MODE != 0) rr_ptr <= ptr_nxt;
            timeout_err <= !own_end;
          end
        end
        SCHED_GAP: begin
          wd_cnt  <= '0;
          gap_cnt <= gap_cnt + 8'd1;
        end
        default: begin
          wd_cnt  <= '0;
          gap_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    gnt         = '0;
    src_cd_busy = '0;
    cd_q        = '0;
    cd_q_rdy    = 1'b0;
    if (in_grant) begin
      gnt[w_q]         = 1'b1;
      src_cd_busy[w_q] = cd_busy;
      cd_q             = src_q[int'(w_q)*8 +: 8];
      cd_q_rdy         = src_q_rdy[w_q];
    end
  end

  assign sched_busy = (state != SCHED_IDLE);

endmodule
